// File: rtl/caesar_pkg.sv
// Shared constants, types and key helpers for the Caesar receive/transmit engines.
package caesar_pkg;

  localparam int unsigned ALPHA_N     = 26;
  localparam int unsigned ASCII_UPPER = 65;
  localparam int unsigned ASCII_LOWER = 97;
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned BYTE_W      = 8;

  typedef enum logic [1:0] {
    NOKEY = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef logic [IDX_W-1:0] letter_t;

  // Classified letter travelling down the pipeline
  typedef struct packed {
    letter_t idx;
    logic    cap;
  } s1_t;

  // Shift values above the alphabet size cannot be committed
  function automatic logic key_legal(input logic [IDX_W-1:0] shift);
    return shift <= IDX_W'(ALPHA_N);
  endfunction

  // A full-alphabet shift is the identity
  function automatic letter_t key_mod(input logic [IDX_W-1:0] shift);
    return (shift == IDX_W'(ALPHA_N)) ? '0 : letter_t'(shift);
  endfunction

endpackage

// File: rtl/caesar_mod26_shift.sv
// Combinational letter index +/- k modulo 26; k must already be reduced to 0..25.
module caesar_mod26_shift
  import caesar_pkg::*;
(
  input  logic [4:0] idx_i,
  input  logic [4:0] k_i,
  input  logic       dec_i,
  output logic [4:0] idx_o
);

  logic [5:0] diff;
  logic [5:0] sum;

  // Six-bit intermediate: bit 5 of the difference flags a borrow below 'a'
  always_comb begin
    diff  = {1'b0, idx_i} - {1'b0, k_i};
    sum   = {1'b0, idx_i} + {1'b0, k_i};
    idx_o = '0;
    if (dec_i) begin
      idx_o = diff[5] ? 5'(diff + 6'(ALPHA_N)) : 5'(diff);
    end else begin
      idx_o = (sum >= 6'(ALPHA_N)) ? 5'(sum - 6'(ALPHA_N)) : 5'(sum);
    end
  end

endmodule

// File: rtl/caesar_ascii_rx.sv
// Streaming ASCII-to-one-hot Caesar receive engine with valid/ready on both sides.
// Optional error counter output err_cnt enabled by defining CAESAR_ERR_CNT_EN.
module caesar_ascii_rx
  import caesar_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_load,
  input  logic [IDX_W-1:0]   key_shift,
  input  logic               key_dec,
  output logic               key_ack,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [BYTE_W-1:0]  s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [ALPHA_N-1:0] m_onehot,
  output logic [IDX_W-1:0]   m_index,
  output logic               m_cap,
  output logic               bad_byte
`ifdef CAESAR_ERR_CNT_EN
  ,
  output logic [15:0]        err_cnt
`endif
);

  state_e             state_q;
  letter_t            key_q, pend_key_q;
  logic               dec_q, pend_dec_q;
  logic               key_ack_q;
  logic               s1_valid_q, s2_valid_q, m_valid_q;
  s1_t                s1_q, s2_q;
  logic [ALPHA_N-1:0] m_onehot_q;
  letter_t            m_index_q;
  logic               m_cap_q;
  logic               bad_byte_q;

  logic    key_req, commit, pipe_empty;
  logic    out_adv, s2_adv, s1_adv, accept;
  logic    is_upper, is_lower, is_letter;
  s1_t     cls_d, s2_d;
  letter_t shift_idx;

  assign key_req    = key_load && key_legal(key_shift);
  assign pipe_empty = !s1_valid_q && !s2_valid_q && !m_valid_q;
  assign commit     = ((state_q == NOKEY) && key_req) || ((state_q == DRAIN) && pipe_empty);

  assign out_adv = !m_valid_q || m_ready;
  assign s2_adv  = !s2_valid_q || out_adv;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign s_ready = (state_q == RUN) && s1_adv && !key_req;
  assign accept  = s_valid && s_ready;

  assign is_upper  = (s_data >= 8'(ASCII_UPPER)) && (s_data < 8'(ASCII_UPPER + ALPHA_N));
  assign is_lower  = (s_data >= 8'(ASCII_LOWER)) && (s_data < 8'(ASCII_LOWER + ALPHA_N));
  assign is_letter = is_upper || is_lower;

  // Stage-1 classification of the incoming byte
  always_comb begin
    cls_d = '0;
    if (is_upper) begin
      cls_d.idx = letter_t'(s_data - 8'(ASCII_UPPER));
      cls_d.cap = 1'b1;
    end else if (is_lower) begin
      cls_d.idx = letter_t'(s_data - 8'(ASCII_LOWER));
    end
  end

  caesar_mod26_shift u_shift (
    .idx_i (s1_q.idx),
    .k_i   (key_q),
    .dec_i (dec_q),
    .idx_o (shift_idx)
  );

  assign s2_d = '{idx: shift_idx, cap: s1_q.cap};

  // Key-management FSM: key commits only with an empty pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= NOKEY;
      key_q      <= '0;
      dec_q      <= 1'b1;
      pend_key_q <= '0;
      pend_dec_q <= 1'b1;
      key_ack_q  <= 1'b0;
    end else begin
      key_ack_q <= 1'b0;
      case (state_q)
        NOKEY: begin
          if (key_req) begin
            key_q     <= key_mod(key_shift);
            dec_q     <= key_dec;
            key_ack_q <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (key_req) begin
            pend_key_q <= key_mod(key_shift);
            pend_dec_q <= key_dec;
            state_q    <= DRAIN;
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            key_q     <= pend_key_q;
            dec_q     <= pend_dec_q;
            key_ack_q <= 1'b1;
            state_q   <= RUN;
          end
        end
        default: state_q <= NOKEY;
      endcase
    end
  end

  // Two pipeline stages: classified byte, then shifted letter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
      bad_byte_q <= 1'b0;
    end else begin
      bad_byte_q <= accept && !is_letter;
      if (s1_adv) begin
        s1_valid_q <= accept && is_letter;
        s1_q       <= cls_d;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        s2_q       <= s2_d;
      end
    end
  end

  // Output register holds its letter until the sink accepts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q  <= 1'b0;
      m_onehot_q <= '0;
      m_index_q  <= '0;
      m_cap_q    <= 1'b0;
    end else if (out_adv) begin
      m_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        m_onehot_q <= ALPHA_N'(1) << s2_q.idx;
        m_index_q  <= s2_q.idx;
        m_cap_q    <= s2_q.cap;
      end
    end
  end

`ifdef CAESAR_ERR_CNT_EN
  localparam int unsigned ERR_W = 16;
  logic [ERR_W-1:0] err_cnt_q;

  // Saturating count of dropped non-letter bytes, cleared on key commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (commit) begin
      err_cnt_q <= '0;
    end else if (accept && !is_letter && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign key_ack  = key_ack_q;
  assign m_valid  = m_valid_q;
  assign m_onehot = m_onehot_q;
  assign m_index  = m_index_q;
  assign m_cap    = m_cap_q;
  assign bad_byte = bad_byte_q;

endmodule

// File: doc/caesar_ascii_rx.md
# caesar_ascii_rx

Streaming receive-side Caesar engine: the inverse of the combinational one-hot-to-ASCII cipher. It accepts ASCII bytes over a valid/ready handshake and classifies each as upper- or lower-case. It un-shifts the letter by a loaded key (mod 26) and emits the letter as a one-hot 26-bit vector, a 5-bit index and a case flag. It sits between a byte source (UART/FIFO) and any logic that consumes one-hot letter lines.

## Interface
Parameters:
- none. Alphabet size 26 and ASCII bases 65/97 are package constants.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- key_load  in  1  request to load key_shift/key_dec
- key_shift  in  5  shift amount 1..26; 26 ≡ 0 (identity); 0 also identity; 27..31 illegal
- key_dec  in  1  1 = subtract shift (decrypt), 0 = add shift (encrypt)
- key_ack  out  1  one-cycle pulse: key committed
- s_valid  in  1  input byte valid
- s_ready  out  1  block can accept s_data
- s_data  in  8  ASCII byte
- m_valid  out  1  output letter valid
- m_ready  in  1  sink accepts output
- m_onehot  out  26  bit k set ⇔ letter index k ('a'/'A' = bit 0)
- m_index  out  5  letter index 0..25
- m_cap  out  1  1 = byte was 'A'..'Z', 0 = 'a'..'z'
- bad_byte  out  1  one-cycle pulse when an accepted byte is not a letter (byte dropped)

## Operation
- FSM states: NOKEY, RUN, DRAIN.
  - NOKEY (reset state): s_ready=0. key_load with legal key_shift → commit key, pulse key_ack, go to RUN.
  - RUN: s_ready = stage-1 can advance. key_load → go to DRAIN, s_ready=0.
  - DRAIN: wait until both pipeline stages and the output register are empty, then commit key, pulse key_ack, return to RUN.
  - Illegal key_shift (27..31) is ignored in every state: no ack, no state change.
- Stage 1 (classify): 65..90 → cap=1, idx=byte−65; 97..122 → cap=0, idx=byte−97; anything else → bad_byte pulse on the accept cycle, byte discarded.
- Stage 2 (shift): k = key_shift mod 26 (26→0).
  - Decrypt: idx−k; a negative result adds 26.
  - Encrypt: idx+k; a result ≥26 subtracts 26.
  - Use a 6-bit intermediate; output index is always 0..25.
- Output register holds m_onehot = 1<<index, m_index and m_cap stable while m_valid=1 and m_ready=0.
- Key change never affects bytes already accepted: they complete with the old key.

## Timing
- Reset values: s_ready=0, m_valid=0, m_onehot=0, m_index=0, m_cap=0, key_ack=0, bad_byte=0; FSM=NOKEY; stored key 0, dec 1.
- Latency: byte accepted at edge N → m_valid at edge N+2 (after the second rising edge).
- Throughput: one byte/cycle when m_ready is held 1.
- Backpressure: each stage advances when its downstream is empty or advancing. No bubble is inserted when m_ready toggles, and no data is lost or duplicated.
- Simultaneous key_load and s_valid in RUN: the byte is not accepted that cycle (s_ready drops combinationally with key_load).
- key_ack comes 1 cycle after key_load in NOKEY. In DRAIN it comes 1 cycle after the pipeline is empty.
- Reset asserted mid-stream: all in-flight bytes are discarded and the block returns to NOKEY.

## Configuration
- CAESAR_ERR_CNT_EN defined: adds output err_cnt (16 bits, reset 0). It increments on each bad_byte pulse and saturates at 65535. It is cleared on key commit.
- CAESAR_ERR_CNT_EN undefined: err_cnt port and logic are absent. bad_byte still pulses.

## Structure
- Shared package caesar_pkg holds:
  - ALPHA_N=26, ASCII_UPPER=65, ASCII_LOWER=97
  - state enum {NOKEY, RUN, DRAIN}
  - letter_t (5-bit index) and the stage-1 struct {idx, cap}
- Sub-module caesar_mod26_shift: combinational index ± k mod 26, reusable by the transmit side.

## Test plan
- Reset, key_shift=3 dec=1 load, stream "DEF" with m_ready=1 → m_index 0,1,2, m_cap=1, m_onehot bits 0,1,2, first m_valid 2 cycles after accept.
- key_shift=26 dec=1, input 'q' (113) → m_index 16, m_cap=0 (identity). key_shift=1 dec=1, input 'a' → m_index 25 (wrap below 0).
- dec=0 key_shift=5, input 'Z' (90) → m_index 4, m_cap=1 (wrap above 25).
- Input '7', ' ', 0xFF interleaved with 'b' → three bad_byte pulses, only 'b' emitted. With CAESAR_ERR_CNT_EN, err_cnt=3.
- Random m_ready deassertion over 100 bytes → output sequence equals the reference-model sequence, with no loss or duplication and outputs stable while stalled.
- key_load with shift 7 while 2 bytes are in flight → s_ready=0 until drained, in-flight bytes use the old key, key_ack follows, the next byte uses shift 7. Also check that a key of 30 is ignored.
